// File: rtl/vga_timing_pkg.sv
// ============================================================================
//  Module  : vga_timing_pkg
//  Brief   : Shared VGA 640x480@60 timing constants, derived bounds, helpers.
//  Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package vga_timing_pkg;

  localparam int c_h_active = 640;
  localparam int c_h_fp     = 16;
  localparam int c_h_sync   = 96;
  localparam int c_h_bp     = 48;
  localparam int c_h_total  = c_h_active + c_h_fp + c_h_sync + c_h_bp;

  localparam int c_v_active = 480;
  localparam int c_v_fp     = 10;
  localparam int c_v_sync   = 2;
  localparam int c_v_bp     = 33;
  localparam int c_v_total  = c_v_active + c_v_fp + c_v_sync + c_v_bp;

  // Sync pulses occupy [start, end) on their axis.
  localparam int c_h_sync_start = c_h_active + c_h_fp;
  localparam int c_h_sync_end   = c_h_sync_start + c_h_sync;
  localparam int c_v_sync_start = c_v_active + c_v_fp;
  localparam int c_v_sync_end   = c_v_sync_start + c_v_sync;

  function automatic logic in_window(input logic [9:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wrap_counter.sv
// ============================================================================
//  Module  : wrap_counter
//  Brief   : Modulo-N enabled counter with look-ahead value and wrap flag.
//  Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module wrap_counter #(
  parameter int MODULUS = 800,
  parameter int WIDTH   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_count_next,
  output logic             o_wrap
);

  localparam logic [WIDTH-1:0] c_last = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_count;
  logic             w_at_last;

  // Reset parks on the last value so the first enabled edge lands on zero.
  always_ff @(posedge clk) begin
    if (rst) r_count <= c_last;
    else     r_count <= o_count_next;
  end

  always_comb begin
    w_at_last    = (r_count == c_last);
    o_wrap       = i_en && w_at_last;
    o_count_next = r_count;
    if (i_en) o_count_next = w_at_last ? '0 : r_count + WIDTH'(1);
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
//  Module  : vga_timing_gen
//  Brief   : VGA raster timing: position counters, blank, syncs, frame count.
//  Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = c_h_active,
  parameter int H_FP     = c_h_fp,
  parameter int H_SYNC   = c_h_sync,
  parameter int H_BP     = c_h_bp,
  parameter int V_ACTIVE = c_v_active,
  parameter int V_FP     = c_v_fp,
  parameter int V_SYNC   = c_v_sync,
  parameter int V_BP     = c_v_bp,
  parameter int FC_W     = 16
) (
  input  logic            vga_clk,
  input  logic            reset,
  output logic [9:0]      DrawX,
  output logic [9:0]      DrawY,
  output logic            blank,
  output logic            hs,
  output logic            vs,
  output logic            line_start,
  output logic            frame_start,
  output logic [FC_W-1:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [9:0]      w_x_next;
  logic [9:0]      w_y_next;
  logic            w_h_wrap;
  logic            w_v_wrap;
  logic            r_blank;
  logic            r_hs;
  logic            r_vs;
  logic            r_line_start;
  logic            r_frame_start;
  logic [FC_W-1:0] r_frame_count;

  wrap_counter #(.MODULUS(H_TOTAL), .WIDTH(10)) u_h_cnt (
    .clk          (vga_clk),
    .rst          (reset),
    .i_en         (1'b1),
    .o_count      (DrawX),
    .o_count_next (w_x_next),
    .o_wrap       (w_h_wrap)
  );

  wrap_counter #(.MODULUS(V_TOTAL), .WIDTH(10)) u_v_cnt (
    .clk          (vga_clk),
    .rst          (reset),
    .i_en         (w_h_wrap),
    .o_count      (DrawY),
    .o_count_next (w_y_next),
    .o_wrap       (w_v_wrap)
  );

  // Decode from the counters' next values so flags land with their position.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_blank       <= 1'b0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_blank       <= in_window(w_x_next, 0, H_ACTIVE) && in_window(w_y_next, 0, V_ACTIVE);
      r_hs          <= !in_window(w_x_next, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC);
      r_vs          <= !in_window(w_y_next, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC);
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_v_wrap;
      if (w_v_wrap) r_frame_count <= r_frame_count + FC_W'(1);
    end
  end

  assign blank       = r_blank;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
//  Module  : tb_vga_timing_gen
//  Brief   : Self-checking bench: reduced-size raster model plus default-size line.
//  Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vga_timing_gen;

  localparam int HA = 16, HF = 3, HS = 5, HB = 4, HT = HA + HF + HS + HB;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] x, y;
  logic       blank, hs, vs, ls, fs;
  logic [2:0] fc;
  logic [9:0] dx, dy;
  logic       dblank, dhs, dvs, dls, dfs;
  logic [15:0] dfc;

  int n_pass = 0;
  int n_total = 0;
  int k = 0;
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .FC_W(3)
  ) dut (
    .vga_clk(clk), .reset(reset), .DrawX(x), .DrawY(y), .blank(blank), .hs(hs), .vs(vs),
    .line_start(ls), .frame_start(fs), .frame_count(fc)
  );

  vga_timing_gen dut_d (
    .vga_clk(clk), .reset(reset), .DrawX(dx), .DrawY(dy), .blank(dblank), .hs(dhs), .vs(dvs),
    .line_start(dls), .frame_start(dfs), .frame_count(dfc)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  // Expected outputs k edges after reset was last sampled (k==0: in reset).
  function automatic logic [27:0] expect_at(input int kk);
    int p, ex, ey, ef;
    logic eb, eh, ev;
    if (kk == 0) return {10'(HT - 1), 10'(VT - 1), 5'b01100, 3'd0};
    p  = kk - 1;
    ex = p % HT;
    ey = (p / HT) % VT;
    ef = p / FRAME;
    eb = (ex < HA) && (ey < VA);
    eh = !((ex >= HA + HF) && (ex < HA + HF + HS));
    ev = !((ey >= VA + VF) && (ey < VA + VF + VS));
    return {10'(ex), 10'(ey), eb, eh, ev, (ex == 0), (ex == 0 && ey == 0), 3'((ef + 1) % 8)};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      k        <= 0;
      model_on <= 1'b1;
    end else begin
      k <= k + 1;
    end
  end

  always @(negedge clk) begin
    if (model_on) chk("model_cycle", {x, y, blank, hs, vs, ls, fs, fc}, expect_at(k));
  end

  initial begin
    int fall_x, hs_low, hs_first, hs_last, ls_at, bl, vl, extra_fs;
    logic pb;
    logic [2:0] fc0;
    bit ok;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", {x, y, blank, hs, vs, ls, fs, fc}, {10'd27, 10'd12, 5'b01100, 3'd0});
    chk("reset_state_default", {dx, dy, dblank, dhs, dvs, dls, dfs, dfc}, {10'd799, 10'd524, 5'b01100, 16'd0});

    reset = 1'b0;
    @(negedge clk);
    chk("first_cycle", {x, y, blank, hs, vs, ls, fs, fc}, {10'd0, 10'd0, 5'b11111, 3'd1});
    chk("first_cycle_default", {dx, dy, dblank, dhs, dvs, dls, dfs, dfc}, {10'd0, 10'd0, 5'b11111, 16'd1});

    // One full default-size line.
    fall_x = -1; hs_low = 0; hs_first = -1; hs_last = -1; ls_at = -1; pb = dblank;
    for (int c = 1; c <= 800; c++) begin
      @(negedge clk);
      if (pb && !dblank && fall_x < 0) fall_x = int'(dx);
      pb = dblank;
      if (!dhs) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(dx);
        hs_last = int'(dx);
      end
      if (dls && ls_at < 0) ls_at = c;
    end
    chk("default_blank_fall_x", 64'(fall_x), 64'd640);
    chk("default_hs_low_cycles", 64'(hs_low), 64'd96);
    chk("default_hs_first_x", 64'(hs_first), 64'd656);
    chk("default_hs_last_x", 64'(hs_last), 64'd751);
    chk("default_line_period", 64'(ls_at), 64'd800);

    // One full reduced-size frame, frame start to frame start.
    ok = 1'b0;
    for (int c = 0; c < 2 * FRAME && !ok; c++) begin
      @(negedge clk);
      if (fs) ok = 1'b1;
    end
    chk("wait_frame_start", 64'(ok), 64'd1);
    fc0 = fc; bl = 0; vl = 0; extra_fs = 0;
    for (int c = 0; c < FRAME; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (fs) extra_fs++;
      end
      if (blank) bl++;
      if (!vs) vl++;
    end
    @(negedge clk);
    chk("blank_high_per_frame", 64'(bl), 64'(HA * VA));
    chk("vs_low_per_frame", 64'(vl), 64'(VS * HT));
    chk("no_early_frame_start", 64'(extra_fs), 64'd0);
    chk("frame_start_spacing", {x, y, fs}, {10'd0, 10'd0, 1'b1});
    chk("frame_count_inc", 64'(fc), 64'(3'(fc0 + 3'd1)));

    // Frame counter wraps 7 -> 0.
    ok = 1'b0;
    for (int c = 0; c < 9 * FRAME && !ok; c++) begin
      @(negedge clk);
      if (fs && fc == 3'd0) ok = 1'b1;
    end
    chk("frame_count_wrap", 64'(ok), 64'd1);

    // Reset pulse mid-frame.
    ok = 1'b0;
    for (int c = 0; c < FRAME + 5 && !ok; c++) begin
      @(negedge clk);
      if (x == 10'd10 && y == 10'd5) ok = 1'b1;
    end
    chk("reach_mid_frame", 64'(ok), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_state", {x, y, blank, hs, vs, fc}, {10'd27, 10'd12, 3'b011, 3'd0});
    reset = 1'b0;
    @(negedge clk);
    chk("after_mid_reset", {x, y, ls, fs, fc}, {10'd0, 10'd0, 2'b11, 3'd1});

    // Randomized reset pulses; the per-cycle model does the checking.
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(1, 700)) @(negedge clk);
      reset = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      reset = 1'b0;
    end
    repeat (FRAME + 2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line, as REQ-002..REQ-011.
REQ-002 H_ACTIVE, 640, visible pixels per line.
REQ-003 H_FP, 16, horizontal front porch clocks.
REQ-004 H_SYNC, 96, horizontal sync width clocks.
REQ-005 H_BP, 48, horizontal back porch clocks; H_TOTAL = sum = 800.
REQ-006 V_ACTIVE, 480, visible lines per frame.
REQ-007 V_FP, 10, vertical front porch lines.
REQ-008 V_SYNC, 2, vertical sync width lines.
REQ-009 V_BP, 33, vertical back porch lines; V_TOTAL = sum = 525.
REQ-010 FC_W, 16, frame_count width.
REQ-011 One clock, vga_clk; reset is synchronous and active-high, port name reset.
REQ-012 SHALL have ports (name, direction, width, meaning), one per line, as REQ-013..REQ-021.
REQ-013 vga_clk  in  1  pixel clock, all logic on posedge.
REQ-014 reset  in  1  synchronous active-high reset.
REQ-015 DrawX  out  10  current horizontal position, 0..H_TOTAL-1.
REQ-016 DrawY  out  10  current line, 0..V_TOTAL-1.
REQ-017 blank  out  1  1 = active display region (downstream drawing enable), 0 = blanking.
REQ-018 hs  out  1  horizontal sync, active-low.
REQ-019 vs  out  1  vertical sync, active-low.
REQ-020 line_start  out  1  one-cycle pulse, high when DrawX==0.
REQ-021 frame_start  out  1  one-cycle pulse, high when DrawX==0 and DrawY==0; frame_count  out  FC_W  frames started since reset, mod 2^FC_W.

Function
REQ-022 DrawX SHALL increment by 1 each clock; at H_TOTAL-1 it wraps to 0 and DrawY increments.
REQ-023 DrawY SHALL wrap from V_TOTAL-1 to 0 on the same clock DrawX wraps.
REQ-024 All outputs SHALL be registered and mutually consistent: in every cycle blank/hs/vs/pulses describe the DrawX/DrawY presented in that same cycle (zero skew).
REQ-025 blank SHALL equal (DrawX < H_ACTIVE) and (DrawY < V_ACTIVE).
REQ-026 hs SHALL be 0 iff H_ACTIVE+H_FP <= DrawX < H_ACTIVE+H_FP+H_SYNC (656..751 default).
REQ-027 vs SHALL be 0 iff V_ACTIVE+V_FP <= DrawY < V_ACTIVE+V_FP+V_SYNC (490..491 default), for all DrawX on those lines.
REQ-028 frame_count SHALL increment, with wrap, in the cycle frame_start is high.
REQ-029 No combinational path from any input to any output.

Reset
REQ-030 While reset is sampled high: DrawX=H_TOTAL-1, DrawY=V_TOTAL-1, blank=0, hs=1, vs=1, line_start=0, frame_start=0, frame_count=0.
REQ-031 First clock after reset is sampled low SHALL present DrawX=0, DrawY=0, blank=1, line_start=1, frame_start=1, frame_count=1.
REQ-032 Reset asserted mid-frame SHALL take effect at the next edge regardless of position; no partial-frame state retained.

Structure
REQ-033 Timing constants and derived H_TOTAL/V_TOTAL/sync bounds SHALL live in shared package vga_timing_pkg, used also by downstream drawing blocks.
REQ-034 One sub-module, wrap_counter (parameterised modulus, enable, wrap flag), SHALL be instantiated twice: horizontal (enable=1) and vertical (enable=horizontal wrap).

Verification
REQ-035 Release reset -> next cycle DrawX=0, DrawY=0, blank=1, frame_start=1, line_start=1, frame_count=1.
REQ-036 Run one line -> blank falls at DrawX=640; hs low exactly 96 consecutive cycles, DrawX 656..751; line_start period 800 cycles.
REQ-037 Run one frame -> vs low exactly 1600 cycles (DrawY 490..491); DrawY 524->0 coincides with DrawX 799->0.
REQ-038 Run two frames -> frame_start spacing 420000 cycles; blank high 307200 cycles per frame; frame_count 1->2.
REQ-039 Assert reset one cycle at DrawX=300, DrawY=200 -> next cycle DrawX=799, DrawY=524, blank=0, hs=1, vs=1, frame_count=0; following cycle DrawX=0, DrawY=0, frame_start=1.
REQ-040 Scoreboard every cycle: blank/hs/vs recomputed from DrawX/DrawY per REQ-025..027 -> zero mismatches.
